tqvp_cattuto_ws2812b_multi: RTL and testbench
=============================================

Name: tqvp_cattuto_ws2812b_multi

Overview:
- Next-generation WS2812B strip driver for the TinyQV byte-peripheral slot.
- Adds a parametrised pixel FIFO with run-length repeat, NUM_CH selectable strip outputs, and parametrised bit/reset timing.
- Contains an integrated bit serializer, so the CPU can queue several pixel runs and poll only FIFO space.

Parameters:
FIFO_DEPTH, 4, pixel-run entries; power of two, 2..16
NUM_CH, 4, strip outputs on uo_out[NUM_CH:1]; 1..7
T0H_CYC, 26, high cycles for a 0 bit (0.4 us at 64 MHz)
T1H_CYC, 51, high cycles for a 1 bit (0.8 us)
TBIT_CYC, 80, total cycles per bit (1.25 us); must exceed T1H_CYC
TRES_CYC, 5120, low cycles for the latch/reset gap (80 us)

Ports:
clk  in  1  project clock, 64 MHz nominal
rst_n  in  1  reset; one clock, synchronous, active-low
ui_in  in  8  input PMOD; unused
uo_out  out  8  uo_out[c+1] = strip channel c; all other bits 0
address  in  4  register address
data_write  in  1  write strobe, one cycle
data_in  in  8  write data
data_out  out  8  read data, combinational on address

Behaviour:
Registers:
- 0x0 CTRL, R/W: [2:0] ch, [7] auto_latch.
  - A write with ch >= NUM_CH leaves ch unchanged; auto_latch still updates.
- 0x1 G, 0x2 R, 0x3 B, R/W: staging colour.
- 0x4 PUSH, W: pushes {ch, G, R, B, rep = data_in} into the FIFO. The run sends rep+1 pixels (1..256).
  - If the FIFO is full the push is dropped and sticky ovf is set.
- 0x5 LATCH, W with any data: sets latch_req.
- 0x6 LEVEL, R: FIFO occupancy, 0..FIFO_DEPTH.
- 0x7 STATUS, R: {4'b0, ovf, latch_req, busy, ~full}. Writing any value clears ovf.
- Undecoded addresses read 0x00; writes to them are ignored.

Reset values:
- Registers, FIFO pointers, ovf and latch_req are all 0.
- FSM in IDLE; uo_out = 0x00; data_out follows address, so 0x01 at address 0x7.

FSM:
- IDLE
  - If the FIFO is non-empty: pop the head into the shift register (GRB, MSB first); go to LOAD.
  - Else if latch_req is set: go to RESET.
- LOAD (1 cycle): bit index = 23, cycle counter = 0; go to SEND.
- SEND
  - Output is high while counter < (bit ? T1H_CYC : T0H_CYC), else low.
  - At counter = TBIT_CYC-1: advance to the next bit.
  - After bit 0: if rep > 0, decrement rep and resend the same colour with no gap. Otherwise go to IDLE.
  - On the return to IDLE, latch_req is set if auto_latch is set and the FIFO is empty.
- RESET: all channels low for TRES_CYC cycles; clear latch_req; go to IDLE.

Timing and channels:
- Popping the next entry from IDLE adds at most 2 cycles between pixels, well inside WS2812B tolerance.
- Only the channel stored in the entry toggles; the other channels stay low.
- busy = (state != IDLE).

Boundary conditions:
- Push and pop in the same cycle: both take effect, level unchanged.
- Push while the FIFO is full: the entry is dropped, no pointer moves, ovf is set.
- LATCH written while busy: held, and executed once the FIFO has drained.
- LATCH written again during RESET: sets latch_req again, giving one further gap.
- Staging and CTRL writes during SEND do not affect the entry in flight.
- Reset mid-frame: output goes low on the next clk edge; the FIFO is flushed.

Optional Feature:
- Macro WS2812B_RGBW_EN.
- When defined:
  - Adds register 0x8 W (R/W) and widens FIFO entries by 8 bits.
  - Each pixel is 32 bits in GRBW order; the bit index starts at 31.
- When undefined: address 0x8 reads 0 and ignores writes; pixels are 24 bits.

Decomposition:
- Package tqvp_ws2812b_pkg holds:
  - register address localparams REG_CTRL..REG_W;
  - FSM state encoding (IDLE, LOAD, SEND, RESET);
  - the PIX_W constant (24, or 32 when RGBW).
- Sub-module ws2812b_fifo: synchronous FIFO with push/pop, full/empty/level outputs.
- The serializer FSM stays in the top module.

Test Plan:
1. CTRL=0x01, G=0x80, R=0x00, B=0x01, PUSH=0x00.
   -> uo_out[2] sends 24 bits: first bit high 51 cycles, the next 22 bits high 26 cycles each, last bit high 51; period 80; uo_out[1] stays 0.
2. PUSH=0x02 with colour 0xFFFFFF.
   -> 3 pixels, 72 consecutive 1-bits with no gap; LEVEL reads 0 after the pop.
3. Push 5 runs of rep=0xFF with FIFO_DEPTH=4 while the first run is sending.
   -> 5th push accepted (slot freed by the pop). 6th push sets STATUS bit3; writing STATUS clears it.
4. auto_latch=1, push one pixel.
   -> after the last bit, the output is low for exactly 5120 cycles; busy falls at the end; latch_req reads 0.
5. LATCH written while idle with the FIFO empty.
   -> RESET entered within 2 cycles, busy for 5120 cycles. CTRL write with ch=7 when NUM_CH=4 -> ch unchanged.
6. rst_n low for 1 cycle at bit 10 of a pixel.
   -> uo_out=0 on the next edge, LEVEL=0, STATUS=0x01.

Source files
------------

// File: rtl/tqvp_ws2812b_pkg.sv
// Shared definitions for the multi-channel WS2812B driver: register map, FSM states, pixel width.
// Pixel width grows to 32 bits (GRBW) when WS2812B_RGBW_EN is defined.
package tqvp_ws2812b_pkg;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_G      = 4'h1;
    localparam logic [3:0] REG_R      = 4'h2;
    localparam logic [3:0] REG_B      = 4'h3;
    localparam logic [3:0] REG_PUSH   = 4'h4;
    localparam logic [3:0] REG_LATCH  = 4'h5;
    localparam logic [3:0] REG_LEVEL  = 4'h6;
    localparam logic [3:0] REG_STATUS = 4'h7;
    localparam logic [3:0] REG_W      = 4'h8;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, RESET} state_t;

`ifdef WS2812B_RGBW_EN
    localparam int PIX_W = 32;
`else
    localparam int PIX_W = 24;
`endif

endpackage

// File: rtl/ws2812b_fifo.sv
// Synchronous pixel-run FIFO; pointers carry one extra wrap bit so full and empty are distinct.
// The head entry is visible combinationally so the serializer can pop and capture in one cycle.
module ws2812b_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tqvp_cattuto_ws2812b_multi.sv
// TinyQV byte peripheral: queued WS2812B pixel runs serialised onto one of NUM_CH strip outputs.
// Define WS2812B_RGBW_EN for 32-bit GRBW pixels and the W staging register at 0x8.
module tqvp_cattuto_ws2812b_multi
    import tqvp_ws2812b_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CH     = 4,
    parameter int T0H_CYC    = 26,
    parameter int T1H_CYC    = 51,
    parameter int TBIT_CYC   = 80,
    parameter int TRES_CYC   = 5120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W   = 3 + PIX_W + 8;
    localparam int CNT_MAX = (TRES_CYC > TBIT_CYC) ? TRES_CYC : TBIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] TBIT_LAST = CNT_W'(TBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TRES_LAST = CNT_W'(TRES_CYC - 1);
    localparam logic [CNT_W-1:0] T0H       = CNT_W'(T0H_CYC);
    localparam logic [CNT_W-1:0] T1H       = CNT_W'(T1H_CYC);
    localparam logic [4:0]       BIT_TOP   = 5'(PIX_W - 1);
    localparam logic [2:0]       NCH       = 3'(NUM_CH);

    state_t             state_q, state_d;
    logic [2:0]         ch_q, ch_d, cur_ch_q, cur_ch_d;
    logic               auto_latch_q, auto_latch_d, ovf_q, ovf_d, latch_req_q, latch_req_d;
    logic [7:0]         g_q, g_d, r_q, r_d, b_q, b_d, rep_q, rep_d, w_rd;
    logic [PIX_W-1:0]   pix_q, pix_d, pix_stage;
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         uo_q, uo_d;
    logic               line_d, cur_bit, busy;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]   fifo_head;
    logic [LVL_W-1:0]   fifo_level;
    logic               unused_ui;

    assign unused_ui = ^ui_in;

`ifdef WS2812B_RGBW_EN
    logic [7:0] w_q, w_d;
    assign pix_stage = {g_q, r_q, b_q, w_q};
    assign w_rd      = w_q;
`else
    assign pix_stage = {g_q, r_q, b_q};
    assign w_rd      = 8'h00;
`endif

    assign fifo_push = data_write && (address == REG_PUSH) && !fifo_full;
    assign busy      = (state_q != IDLE);

    ws2812b_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({ch_q, pix_stage, data_in}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        auto_latch_d = auto_latch_q;
        g_d          = g_q;
        r_d          = r_q;
        b_d          = b_q;
`ifdef WS2812B_RGBW_EN
        w_d          = w_q;
`endif
        ovf_d        = ovf_q;
        latch_req_d  = latch_req_q;
        cur_ch_d     = cur_ch_q;
        pix_d        = pix_q;
        rep_d        = rep_q;
        bit_idx_d    = bit_idx_q;
        cnt_d        = cnt_q;
        fifo_pop     = 1'b0;

        if (data_write) begin
            case (address)
                REG_CTRL: begin
                    if (data_in[2:0] < NCH) ch_d = data_in[2:0];
                    auto_latch_d = data_in[7];
                end
                REG_G:      g_d = data_in;
                REG_R:      r_d = data_in;
                REG_B:      b_d = data_in;
`ifdef WS2812B_RGBW_EN
                REG_W:      w_d = data_in;
`endif
                REG_PUSH:   if (fifo_full) ovf_d = 1'b1;
                REG_STATUS: ovf_d = 1'b0;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_ch_d = fifo_head[ENT_W-1 -: 3];
                    pix_d    = fifo_head[8 +: PIX_W];
                    rep_d    = fifo_head[7:0];
                    state_d  = LOAD;
                end else if (latch_req_q) begin
                    latch_req_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = RESET;
                end
            end
            LOAD: begin
                bit_idx_d = BIT_TOP;
                cnt_d     = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (cnt_q == TBIT_LAST) begin
                    cnt_d = '0;
                    if (bit_idx_q != 5'd0) begin
                        bit_idx_d = bit_idx_q - 5'd1;
                    end else if (rep_q != 8'd0) begin
                        rep_d     = rep_q - 8'd1;
                        bit_idx_d = BIT_TOP;
                    end else begin
                        state_d = IDLE;
                        if (auto_latch_q && fifo_empty) latch_req_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESET: begin
                if (cnt_q == TRES_LAST) state_d = IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A LATCH write wins over the clear on RESET entry, so it buys one more gap.
        if (data_write && (address == REG_LATCH)) latch_req_d = 1'b1;
    end

    // Output is derived from next-state values so the registered pin lines up with state_q.
    always_comb begin
        cur_bit = pix_d[bit_idx_d];
        line_d  = (state_d == SEND) && (cnt_d < (cur_bit ? T1H : T0H));
    end

    assign uo_d[0] = 1'b0;
    for (genvar gi = 0; gi < 7; gi++) begin : g_ch
        if (gi < NUM_CH) begin : g_on
            assign uo_d[gi+1] = line_d && (cur_ch_d == 3'(gi));
        end else begin : g_off
            assign uo_d[gi+1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            auto_latch_q <= 1'b0;
            g_q          <= '0;
            r_q          <= '0;
            b_q          <= '0;
`ifdef WS2812B_RGBW_EN
            w_q          <= '0;
`endif
            ovf_q        <= 1'b0;
            latch_req_q  <= 1'b0;
            cur_ch_q     <= '0;
            pix_q        <= '0;
            rep_q        <= '0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            uo_q         <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            auto_latch_q <= auto_latch_d;
            g_q          <= g_d;
            r_q          <= r_d;
            b_q          <= b_d;
`ifdef WS2812B_RGBW_EN
            w_q          <= w_d;
`endif
            ovf_q        <= ovf_d;
            latch_req_q  <= latch_req_d;
            cur_ch_q     <= cur_ch_d;
            pix_q        <= pix_d;
            rep_q        <= rep_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            uo_q         <= uo_d;
        end
    end

    assign uo_out = uo_q;

    always_comb begin
        case (address)
            REG_CTRL:   data_out = {auto_latch_q, 4'b0000, ch_q};
            REG_G:      data_out = g_q;
            REG_R:      data_out = r_q;
            REG_B:      data_out = b_q;
            REG_LEVEL:  data_out = 8'(fifo_level);
            REG_STATUS: data_out = {4'b0000, ovf_q, latch_req_q, busy, ~fifo_full};
            REG_W:      data_out = w_rd;
            default:    data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_cattuto_ws2812b_multi.sv
// Directed bench for the multi-channel WS2812B driver: register table plus timed strip sequences.
module tb_tqvp_cattuto_ws2812b_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    int total = 0;
    int bad = 0;
    int hi_len[80];
    int per_len[80];
    int other_bad;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    tqvp_cattuto_ws2812b_multi dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    // Measures high time and period of nbits bits on strip ch; period of the last bit is not measured.
    task automatic measure(input int nbits, input int ch, output bit ok);
        logic [7:0] other_mask;
        other_mask = ~(8'd1 << (ch + 1));
        other_bad = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (uo_out[ch+1]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        for (int b = 0; b < nbits; b++) begin
            int hi;
            int lo;
            hi = 0;
            lo = 0;
            while (uo_out[ch+1] && hi < 300) begin
                if ((uo_out & other_mask) != 8'h00) other_bad++;
                hi++;
                tick();
            end
            if (b != nbits - 1) begin
                while (!uo_out[ch+1] && lo < 300) begin
                    if ((uo_out & other_mask) != 8'h00) other_bad++;
                    lo++;
                    tick();
                end
            end
            hi_len[b] = hi;
            per_len[b] = hi + lo;
        end
    endtask

    task automatic check_bits(input string tag, input int nbits, input logic [79:0] bits);
        for (int b = 0; b < nbits; b++) begin
            check($sformatf("%s_hi[%0d]", tag, b), hi_len[b], bits[nbits-1-b] ? 51 : 26);
            if (b != nbits - 1) check($sformatf("%s_per[%0d]", tag, b), per_len[b], 80);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        address = 4'h7;
        #1;
        while (data_out[1] && n < 500) begin
            n++;
            tick();
        end
        check(name, data_out[1], 1'b0);
    endtask

    initial begin
        bit ok;
        int n;
        int w;
        int rises;
        logic prev;
        logic [79:0] bits;

        vecs[0]  = '{1'b0, 4'h7, 8'h00, 8'h01};
        vecs[1]  = '{1'b0, 4'h6, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 4'h0, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 4'h8, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 4'hF, 8'h00, 8'h00};
        vecs[5]  = '{1'b1, 4'h1, 8'h80, 8'h80};
        vecs[6]  = '{1'b1, 4'h2, 8'h5A, 8'h5A};
        vecs[7]  = '{1'b1, 4'h3, 8'h01, 8'h01};
        vecs[8]  = '{1'b1, 4'h2, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 4'h0, 8'h03, 8'h03};
        vecs[10] = '{1'b1, 4'h0, 8'h87, 8'h83};
        vecs[11] = '{1'b1, 4'h0, 8'h04, 8'h03};
        vecs[12] = '{1'b1, 4'h0, 8'h01, 8'h01};
`ifdef WS2812B_RGBW_EN
        vecs[13] = '{1'b1, 4'h8, 8'h55, 8'h55};
`else
        vecs[13] = '{1'b1, 4'h8, 8'h55, 8'h00};
`endif
        vecs[14] = '{1'b1, 4'h9, 8'h33, 8'h00};
        vecs[15] = '{1'b1, 4'h7, 8'hFF, 8'h01};

        tick(); tick(); tick();
        check("reset_uo", uo_out, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
            rd_check($sformatf("reg_vec[%0d]", i), vecs[i].addr, vecs[i].exp);
            $display("reg vec %0d: wr=%0b addr=0x%0h wdata=0x%02h read=0x%02h", i, vecs[i].wr, vecs[i].addr, vecs[i].wdata, data_out);
            tick();
        end
        rd_check("stage_g_kept", 4'h1, 8'h80);
        tick();

        // One pixel 0x800001 on channel 1.
        wr(4'h4, 8'h00);
        measure(24, 1, ok);
        check("t1_started", ok, 1'b1);
        bits = 80'h800001;
        check_bits("t1", 24, bits);
        check("t1_other_ch", other_bad, 0);
        $display("seq 1: single pixel ch1 first_hi=%0d last_hi=%0d", hi_len[0], hi_len[23]);
        wait_idle("t1_idle");

        // Three repeats of white with no inter-pixel gap.
        wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
        wr(4'h4, 8'h02);
        measure(72, 1, ok);
        check("t2_started", ok, 1'b1);
        bits = {8'h00, 72'hFFFFFF_FFFFFF_FFFFFF};
        check_bits("t2", 72, bits);
        rd_check("t2_level", 4'h6, 8'h00);
        rd_check("t2_status", 4'h7, 8'h03);
        $display("seq 2: repeat run ch1 bits=72 level=0");
        tick();
        wait_idle("t2_idle");

        // Fill the FIFO behind a long run, then overflow it.
        wr(4'h0, 8'h00);
        wr(4'h4, 8'hFF);
        tick(); tick(); tick();
        rd_check("t3_first_popped", 4'h6, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) wr(4'h4, 8'hFF);
        rd_check("t3_level_full", 4'h6, 8'h04);
        rd_check("t3_status_full", 4'h7, 8'h02);
        tick();
        wr(4'h4, 8'hFF);
        rd_check("t3_status_ovf", 4'h7, 8'h0A);
        rd_check("t3_level_kept", 4'h6, 8'h04);
        tick();
        wr(4'h7, 8'h00);
        rd_check("t3_ovf_cleared", 4'h7, 8'h02);
        $display("seq 3: fifo filled, overflow flagged and cleared");
        tick();

        // Reset partway through a pixel.
        n = 0;
        while (!uo_out[1] && n < 400) begin n++; tick(); end
        prev = uo_out[1];
        rises = 0;
        for (int i = 0; i < 3000 && rises < 10; i++) begin
            tick();
            if (uo_out[1] && !prev) rises++;
            prev = uo_out[1];
        end
        check("t6_rises", rises, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_uo_low", uo_out, 8'h00);
        rd_check("t6_level", 4'h6, 8'h00);
        rd_check("t6_status", 4'h7, 8'h01);
        rd_check("t6_ctrl", 4'h0, 8'h00);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (uo_out != 8'h00) n++;
        end
        check("t6_stays_low", n, 0);
        $display("seq 6: mid-frame reset flushed fifo");

        // auto_latch: one black pixel on channel 2 followed by the latch gap.
        wr(4'h0, 8'h82);
        wr(4'h4, 8'h00);
        measure(24, 2, ok);
        check("t4_started", ok, 1'b1);
        bits = 80'h0;
        check_bits("t4", 24, bits);
        address = 4'h7;
        #1;
        n = 0;
        while (data_out[1] && n < 200) begin n++; tick(); end
        check("t4_idle_latch", data_out, 8'h05);
        tick();
        n = 0;
        w = 0;
        while (data_out[1] && n < 6000) begin
            if (uo_out != 8'h00) w++;
            n++;
            tick();
        end
        check("t4_gap_len", n, 5120);
        check("t4_gap_low", w, 0);
        check("t4_status_end", data_out, 8'h01);
        $display("seq 4: auto latch gap=%0d", n);

        // Manual LATCH while idle, re-armed during the gap.
        wr(4'h0, 8'h01);
        wr(4'h5, 8'h00);
        rd_check("t5_latch_req", 4'h7, 8'h05);
        w = 0;
        while (!data_out[1] && w < 3) begin w++; tick(); end
        check("t5_reset_entered", data_out[1], 1'b1);
        n = 0;
        while (data_out[1] && n < 6000) begin
            n++;
            if (n == 100) begin
                address = 4'h5;
                data_write = 1'b1;
                tick();
                data_write = 1'b0;
                address = 4'h7;
                #1;
            end else begin
                tick();
            end
        end
        check("t5_gap1_len", n, 5120);
        check("t5_rearmed", data_out, 8'h05);
        tick();
        n = 0;
        while (data_out[1] && n < 6000) begin n++; tick(); end
        check("t5_gap2_len", n, 5120);
        check("t5_status_end", data_out, 8'h01);
        rd_check("t5_ctrl_kept", 4'h0, 8'h01);
        $display("seq 5: latch gaps done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
